// File: rtl/lvdc_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lvdc_timing_pkg
//  Description : Shared types and helpers for the LVDC timing sequencer.
//                Holds the run-state encoding, the default timing-chain sizes
//                and the bit-time/phase advance function.
//  Revision    : 1.0  initial release
// ============================================================================
package lvdc_timing_pkg;

    // Fixed 2-bit encodings. HALTED is all-zero so a cleared copy is halted.
    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_t;

    localparam int c_DEF_BIT_TIMES = 14;  // 13 data bits + parity
    localparam int c_DEF_PHASES    = 3;

    // Bit time never exceeds 15 (at most 16 bit times), so 4 bits carry it.
    typedef struct packed {
        logic [3:0] bt;    // next bit time
        logic [1:0] ph;    // next phase
        logic       wrap;  // bit time wraps to 0
        logic       last;  // wrap out of the final phase
    } count_t;

    // Advance the (bit_time, phase) pair by one bit. Out-of-range inputs
    // (only possible after a multi-copy upset) are treated as a wrap.
    function automatic count_t next_count(input logic [3:0] bt,
                                          input logic [1:0] ph,
                                          input int         bit_times,
                                          input int         phases);
        count_t nc;
        nc.wrap = (int'(bt) >= bit_times - 1);
        nc.last = nc.wrap && (int'(ph) >= phases - 1);
        nc.bt   = nc.wrap ? 4'd0 : 4'(int'(bt) + 1);
        if (!nc.wrap)
            nc.ph = ph;
        else if (nc.last)
            nc.ph = 2'd0;
        else
            nc.ph = 2'(int'(ph) + 1);
        return nc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lvdc_timing_sequencer_vote.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_vote3
//  Description : Bitwise 2-of-3 majority voter with per-input disagree flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tmr_vote3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_voted,
    output logic [2:0]       o_disagree
);

    // Majority per bit; a flag marks any input that lost at least one bit.
    always_comb begin
        o_voted       = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
        o_disagree[0] = |(i_a ^ o_voted);
        o_disagree[1] = |(i_b ^ o_voted);
        o_disagree[2] = |(i_c ^ o_voted);
    end

endmodule
`default_nettype wire

// File: rtl/lvdc_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lvdc_timing_sequencer
//  Description : LVDC timing chain. Counts bit times and phases from the
//                clock-logic bit strobe, with maintenance halt/single-step
//                that stops only on phase boundaries. State is kept in three
//                redundant copies, majority voted every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module lvdc_timing_sequencer
    import lvdc_timing_pkg::*;
#(
    parameter int BIT_TIMES = c_DEF_BIT_TIMES,
    parameter int PHASES    = c_DEF_PHASES,
    parameter int BT_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_en,
    input  logic            halt_req,
    input  logic            step_req,
    input  logic [2:0]      inject_fault,
    output logic [BT_W-1:0] bit_time,
    output logic [1:0]      phase,
    output logic            bit_strobe,
    output logic            phase_start,
    output logic            cycle_end,
    output logic            halted,
    output logic [2:0]      tmr_miscompare
);

    // Copy layout: {state, phase, bit_time}
    localparam int c_W = 2 + 2 + BT_W;

    logic [c_W-1:0]  r_copy [3];
    logic [c_W-1:0]  w_voted;
    logic [c_W-1:0]  w_next;
    logic [2:0]      w_disagree;
    state_t          w_state;
    state_t          w_state_nx;
    logic [1:0]      w_ph;
    logic [1:0]      w_ph_nx;
    logic [BT_W-1:0] w_bt;
    logic [BT_W-1:0] w_bt_nx;
    logic            w_count_en;
    logic            w_wrap;
    count_t          w_cnt;
    logic            r_bit_strobe;
    logic            r_phase_start;
    logic            r_cycle_end;
    logic [2:0]      r_miscompare;

    tmr_vote3 #(.WIDTH(c_W)) u_vote (
        .i_a        (r_copy[0]),
        .i_b        (r_copy[1]),
        .i_c        (r_copy[2]),
        .o_voted    (w_voted),
        .o_disagree (w_disagree)
    );

    assign w_state = state_t'(w_voted[c_W-1 -: 2]);
    assign w_ph    = w_voted[BT_W +: 2];
    assign w_bt    = w_voted[BT_W-1:0];

    // Next state and counters, always derived from the voted value.
    always_comb begin
        w_state_nx = w_state;
        w_ph_nx    = w_ph;
        w_bt_nx    = w_bt;
        w_cnt      = next_count(4'(w_bt), w_ph, BIT_TIMES, PHASES);
        w_count_en = bit_en && ((w_state == ST_RUN) || (w_state == ST_STEP));
        w_wrap     = w_count_en && w_cnt.wrap;
        if (w_count_en) begin
            w_bt_nx = BT_W'(w_cnt.bt);
            w_ph_nx = w_cnt.ph;
        end
        case (w_state)
            ST_HALTED: begin
                if (step_req)
                    w_state_nx = ST_STEP;
                else if (!halt_req)
                    w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (w_wrap && halt_req)
                    w_state_nx = ST_HALTED;
            end
            ST_STEP: begin
                if (w_wrap)
                    w_state_nx = ST_HALTED;
            end
            default: w_state_nx = ST_HALTED;
        endcase
        w_next = {w_state_nx, w_ph_nx, w_bt_nx};
    end

    // Three redundant copies all load the same voted next value; the test
    // input can flip bit 0 of any copy's bit time for a single cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)
                r_copy[i] <= {ST_HALTED, 2'd0, {BT_W{1'b0}}};
            else
                r_copy[i] <= w_next ^ c_W'(inject_fault[i]);
        end
    end

    // Registered strobes and sticky miscompare flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_strobe  <= 1'b0;
            r_phase_start <= 1'b0;
            r_cycle_end   <= 1'b0;
            r_miscompare  <= 3'b000;
        end else begin
            r_bit_strobe  <= w_count_en;
            r_phase_start <= w_wrap;
            r_cycle_end   <= w_wrap && w_cnt.last;
            r_miscompare  <= r_miscompare | w_disagree;
        end
    end

    assign bit_time       = w_bt;
    assign phase          = w_ph;
    assign halted         = (w_state == ST_HALTED);
    assign bit_strobe     = r_bit_strobe;
    assign phase_start    = r_phase_start;
    assign cycle_end      = r_cycle_end;
    assign tmr_miscompare = r_miscompare;

endmodule
`default_nettype wire

// File: tb/tb_lvdc_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lvdc_timing_sequencer
//  Description : Directed/randomised bench for lvdc_timing_sequencer. The
//                expected counters come from a strobe count n:
//                bit_time = n mod BIT_TIMES, phase = (n div BIT_TIMES) mod PHASES.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lvdc_timing_sequencer;

    localparam int BT  = 14;
    localparam int PH  = 3;
    localparam int BT2 = 4;
    localparam int PH2 = 2;

    logic       clk = 1'b0;
    logic       rst, bit_en, halt_req, step_req;
    logic [2:0] inject_fault;
    logic [3:0] bit_time;
    logic [1:0] phase;
    logic       bit_strobe, phase_start, cycle_end, halted;
    logic [2:0] tmr_miscompare;

    logic       rst2, bit_en2, halt2, step2;
    logic [2:0] inject2;
    logic [3:0] bit_time2;
    logic [1:0] phase2;
    logic       bit_strobe2, phase_start2, cycle_end2, halted2;
    logic [2:0] miscompare2;

    int errors = 0;
    int checks = 0;
    int n      = 0;   // counting strobes seen by the default instance
    int n2     = 0;   // counting strobes seen by the small instance
    int ps_cnt = 0;   // phase_start pulses within the first cycle

    always #5 clk = ~clk;

    lvdc_timing_sequencer dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .halt_req(halt_req),
        .step_req(step_req), .inject_fault(inject_fault),
        .bit_time(bit_time), .phase(phase), .bit_strobe(bit_strobe),
        .phase_start(phase_start), .cycle_end(cycle_end), .halted(halted),
        .tmr_miscompare(tmr_miscompare)
    );

    lvdc_timing_sequencer #(.BIT_TIMES(BT2), .PHASES(PH2), .BT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .bit_en(bit_en2), .halt_req(halt2),
        .step_req(step2), .inject_fault(inject2),
        .bit_time(bit_time2), .phase(phase2), .bit_strobe(bit_strobe2),
        .phase_start(phase_start2), .cycle_end(cycle_end2), .halted(halted2),
        .tmr_miscompare(miscompare2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit_en pulse to the default instance, then a random idle gap.
    task automatic strobe(input bit counts);
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        if (counts) n++;
        chk("bit_strobe", bit_strobe, counts);
        chk("bit_time", bit_time, n % BT);
        chk("phase", phase, (n / BT) % PH);
        chk("cycle_end", cycle_end, counts && (n % (BT * PH) == 0));
        if (!counts)
            chk("phase_start_idle", phase_start, 0);
        else if (n % (BT * PH) != 0)
            chk("phase_start", phase_start, (n % BT) == 0);
        if (phase_start === 1'b1 && n < BT * PH) ps_cnt++;
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("bit_strobe_gap", bit_strobe, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bit_en = 1'b1; halt_req = 1'b0; step_req = 1'b0; inject_fault = 3'b000;
        rst2 = 1'b1; bit_en2 = 1'b0; halt2 = 1'b0; step2 = 1'b0; inject2 = 3'b000;
        tick();
        tick();
        // Reset state, with bit_en held high through reset.
        chk("rst_bit_time", bit_time, 0);
        chk("rst_phase", phase, 0);
        chk("rst_halted", halted, 1);
        chk("rst_bit_strobe", bit_strobe, 0);
        chk("rst_phase_start", phase_start, 0);
        chk("rst_cycle_end", cycle_end, 0);
        chk("rst_miscompare", tmr_miscompare, 0);

        bit_en = 1'b0; rst = 1'b0;
        tick();
        chk("run_after_release", halted, 0);

        // One full instruction cycle.
        for (int i = 0; i < BT * PH; i++) strobe(1'b1);
        chk("phase_start_count", ps_cnt, 2);

        // Run to bit 5 of phase 1, then request a halt.
        for (int i = 0; i < BT + 5; i++) strobe(1'b1);
        chk("pre_halt_bt", bit_time, 5);
        chk("pre_halt_ph", phase, 1);
        halt_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1);
            chk("halt_not_yet", halted, 0);
        end
        strobe(1'b1);
        chk("halted_at_boundary", halted, 1);
        chk("halt_bt", bit_time, 0);
        chk("halt_ph", phase, 2);
        for (int i = 0; i < 3; i++) strobe(1'b0);

        // Single step with halt_req still high.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_leaves_halt", halted, 0);
        for (int i = 0; i < BT; i++) begin
            strobe(1'b1);
            chk("step_halted", halted, (i == BT - 1));
        end
        chk("step_end_ph", phase, 0);
        strobe(1'b0);

        // Resume and inject a single-copy fault at bit 7.
        halt_req = 1'b0;
        tick();
        chk("resume", halted, 0);
        for (int i = 0; i < 7; i++) strobe(1'b1);
        inject_fault = 3'b010;
        tick();
        inject_fault = 3'b000;
        chk("fault_voted_bt", bit_time, 7);
        tick();
        chk("fault_flag", tmr_miscompare, 3'b010);
        chk("fault_resync", dut.r_copy[1][3:0], 7);
        chk("fault_bt_after", bit_time, 7);
        tick();
        chk("fault_sticky", tmr_miscompare, 3'b010);

        // Run to bit 13 of phase 2, then reset coincident with bit_en.
        while (!((n % BT == BT - 1) && ((n / BT) % PH == PH - 1))) strobe(1'b1);
        rst = 1'b1; bit_en = 1'b1;
        tick();
        rst = 1'b0; bit_en = 1'b0;
        chk("rst_mid_cycle_end", cycle_end, 0);
        chk("rst_mid_bt", bit_time, 0);
        chk("rst_mid_ph", phase, 0);
        chk("rst_mid_halted", halted, 1);
        chk("rst_mid_miscompare", tmr_miscompare, 0);
        n = 0;

        // Double fault: only the flags are checked.
        tick();
        inject_fault = 3'b011;
        tick();
        inject_fault = 3'b000;
        tick();
        chk("double_fault_flags", tmr_miscompare != 3'b000, 1);

        // Small configuration: 4 bit times x 2 phases.
        rst2 = 1'b0;
        tick();
        chk("small_run", halted2, 0);
        for (int i = 0; i < 24; i++) begin
            bit_en2 = 1'b1;
            tick();
            bit_en2 = 1'b0;
            n2++;
            chk("small_bt", bit_time2, n2 % BT2);
            chk("small_bt_max", bit_time2 <= 4'd3, 1);
            chk("small_ph", phase2, (n2 / BT2) % PH2);
            chk("small_cycle_end", cycle_end2, (n2 % (BT2 * PH2)) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lvdc_timing_sequencer.md
Name: lvdc_timing_sequencer

Overview:
- Sequences the LVDC computer timing chain from the clock-logic bit strobe.
- Produces bit-time and phase counters for the arithmetic and memory datapath, with phase-boundary strobes.
- Holds its state in triple-modular-redundant (TMR) form, matching the clock logic: three register copies, majority voted every cycle.
- Provides a maintenance halt/single-step handshake that stops the machine only on phase boundaries.

Parameters:
- BIT_TIMES, 14, bit times per phase (13 data bits + parity); legal range 2..16.
- PHASES, 3, phases per instruction cycle; legal range 2..4.
- BT_W, 4, width of bit_time; must satisfy 2**BT_W >= BIT_TIMES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_en  in  1  one-cycle strobe per bit time, derived from the A1R phase output of clock_logic.
- halt_req  in  1  level; request a stop at the next phase boundary.
- step_req  in  1  one-cycle pulse; while halted, run exactly one phase.
- inject_fault  in  3  test only; bit i flips bit 0 of copy i's bit-time register for one cycle.
- bit_time  out  BT_W  voted bit-time counter.
- phase  out  2  voted phase counter.
- bit_strobe  out  1  bit_en gated by run state, registered.
- phase_start  out  1  pulse on the cycle that bit_time becomes 0.
- cycle_end  out  1  pulse when the last bit of the last phase completes.
- halted  out  1  1 while in HALTED.
- tmr_miscompare  out  3  sticky; bit i set when copy i disagreed with the vote.

Behaviour:
- Reset (synchronous, active-high):
  - All three copies cleared: bit_time=0, phase=0.
  - State = HALTED, halted=1.
  - All strobes 0; tmr_miscompare cleared.
- States and transitions:
  - HALTED -> RUN when halt_req=0 and step_req=0.
  - HALTED -> STEP when step_req=1. Step wins over halt_req; step_req is ignored outside HALTED.
  - RUN -> HALTED at a phase boundary with halt_req=1. A phase boundary is a bit_en advancing bit_time from BIT_TIMES-1 to 0.
  - STEP -> HALTED at the next phase boundary, regardless of halt_req.
  - A halt_req pulse that falls before the boundary is lost; halt_req is level-sensitive.
- Counting:
  - Counting occurs only on cycles with bit_en=1 in RUN or STEP.
  - bit_time increments modulo BIT_TIMES.
  - On wrap, phase increments modulo PHASES.
  - Counters are unchanged in HALTED, and the values at halt are retained.
- Output timing:
  - bit_strobe, phase_start and cycle_end are registered, 1-cycle latency after the counting bit_en.
  - phase_start=1 on the cycle the new voted bit_time=0 first appears.
  - cycle_end=1 when the wrap occurs from bit BIT_TIMES-1 of phase PHASES-1.
  - At reset exit the counters are already at 0/0, so no phase_start is issued for them.
  - On resume from HALTED, the first counting bit_en produces bit_time 1.
- Halt timing:
  - halted rises the cycle after the boundary.
  - halted falls the cycle after the exit condition is sampled.
- TMR:
  - Each copy computes next state from the voted current value, not from its own value.
  - The vote is bitwise majority of the three copies, covering bit_time, phase and the state encoding.
  - A single corrupted copy is out-voted and resynchronised on the next clock.
  - tmr_miscompare[i] sets on the cycle copy i differs from the vote and holds until rst.
- Boundary conditions:
  - rst asserted mid-phase overrides everything in the same edge.
  - bit_en coincident with rst is ignored.
  - inject_fault on two copies simultaneously is outside the fault model, and output corruption is permitted. The bench checks only that the miscompare flags set.

Decomposition:
- Package lvdc_timing_pkg:
  - state enum {HALTED, RUN, STEP} with fixed 2-bit encodings.
  - Default BIT_TIMES and PHASES constants.
  - Function next_count(bt, ph) returning the wrapped pair.
- Sub-module tmr_vote3, parameterised WIDTH:
  - Bitwise majority of a, b, c.
  - Per-input disagree flags.
  - Instantiated once over the concatenated {state, phase, bit_time} vector.

Test Plan:
- Reset then release, halt_req=0, bit_en every 4 clocks for 42 strobes -> phase sequence 0,1,2. phase_start fires 2 times, at the wraps into phase 1 and phase 2. cycle_end fires once, 1 clk after the 42nd strobe, with bit_time=0, phase=0.
- Assert halt_req at bit_time=5, phase=1 -> counting continues to bit 13. Halt on the wrap, bit_time=0, phase=2, halted=1; subsequent bit_en are ignored.
- While halted, pulse step_req with halt_req=1 -> exactly 14 bit strobes. phase goes 2->0; halted drops 1 clk after step_req and re-asserts 1 clk after the wrap.
- inject_fault=3'b010 for one clk at bit_time=7 -> bit_time output stays 7. tmr_miscompare=3'b010 sticky; copy 1 equals the vote on the next clk.
- rst asserted coincident with bit_en at bit_time=13, phase=2 -> no cycle_end. Next-clk outputs: bit_time=0, phase=0, halted=1, tmr_miscompare=0.
- Parameters BIT_TIMES=4, PHASES=2 -> cycle_end every 8 bit strobes; bit_time never exceeds 3.
